prng_bit_packer: RTL and testbench

Downstream consumer of the cellular-automaton PRNG core. Each clock it samples one tap cell of the free-running N-bit CA state, packs consecutive samples into W-bit random words, and delivers them through a small FIFO with a valid/ready handshake. A configurable warm-up period after enable discards samples taken while the CA is still close to its seed. A saturating counter records words dropped under sustained back-pressure.

---
 rtl/prng_pkg.sv | 16 +
 rtl/prng_word_fifo.sv | 50 +++++
 rtl/prng_bit_packer.sv | 138 +++++++++++++
 tb/tb_prng_bit_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and helpers for the PRNG consumer and health blocks.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        COLLECT = 2'd2
    } pack_state_t;

    localparam int OVF_W = 8;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] value);
        return (value == {OVF_W{1'b1}}) ? value : value + OVF_W'(1);
    endfunction

endpackage

// File: rtl/prng_word_fifo.sv
// Small word FIFO; pointers carry one extra wrap bit so full and empty differ.
module prng_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wrPtr;
    logic [AW:0]  r_rdPtr;
    logic         w_doPush;
    logic         w_doPop;

    assign empty    = (r_wrPtr == r_rdPtr);
    assign full     = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
    assign w_doPop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign w_doPush = push && (!full || w_doPop);
    assign rd_data  = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr[AW-1:0]] <= push_data;
                r_wrPtr                <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/prng_bit_packer.sv
// Packs one CA tap cell per clock into W-bit words after a warm-up period
// and hands them out through a small valid/ready FIFO.
module prng_bit_packer
    import prng_pkg::pack_state_t;
    import prng_pkg::OVF_W;
    import prng_pkg::sat_inc;
#(
    parameter int N      = 32,
    parameter int W      = 32,
    parameter int TAP    = N / 2,
    parameter int WARMUP = 64,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     ca_state,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             busy
);

    localparam int BCW = $clog2(W);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WC_LOAD  = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);

    pack_state_t      r_state;
    pack_state_t      w_nextState;
    logic [WCW-1:0]   r_warmCnt;
    logic [BCW-1:0]   r_bitCnt;
    logic [W-1:0]     r_acc;
    logic [OVF_W-1:0] r_ovfCnt;
    logic             w_sample;
    logic             w_wordDone;
    logic [W-1:0]     w_word;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_unusedCaBits;

    assign w_unusedCaBits = ^ca_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= prng_pkg::IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            prng_pkg::IDLE: begin
                if (en) begin
                    w_nextState = (WARMUP > 0) ? prng_pkg::WARMUP : prng_pkg::COLLECT;
                end
            end
            prng_pkg::WARMUP: begin
                if (!en) begin
                    w_nextState = prng_pkg::IDLE;
                end else if (r_warmCnt == '0) begin
                    w_nextState = prng_pkg::COLLECT;
                end
            end
            prng_pkg::COLLECT: begin
                if (!en) begin
                    w_nextState = prng_pkg::IDLE;
                end
            end
            default: w_nextState = prng_pkg::IDLE;
        endcase
    end

    // The finishing sample goes straight into the pushed word, not via r_acc.
    always_comb begin
        w_sample           = (r_state == prng_pkg::COLLECT) && en;
        w_wordDone         = w_sample && (r_bitCnt == BIT_LAST);
        busy               = (r_state != prng_pkg::IDLE);
        w_word             = r_acc;
        w_word[r_bitCnt]   = ca_state[TAP];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warmCnt <= '0;
        end else if (r_state == prng_pkg::IDLE) begin
            if (en) begin
                r_warmCnt <= WC_LOAD;
            end
        end else if (r_state == prng_pkg::WARMUP && r_warmCnt != '0) begin
            r_warmCnt <= r_warmCnt - WCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt <= '0;
            r_acc    <= '0;
        end else if (!w_sample || w_wordDone) begin
            r_bitCnt <= '0;
            r_acc    <= '0;
        end else begin
            r_bitCnt <= r_bitCnt + BCW'(1);
            r_acc    <= w_word;
        end
    end

    assign w_pop     = out_ready && !w_empty;
    assign out_valid = !w_empty;
    assign ovf_cnt   = r_ovfCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovfCnt <= '0;
        end else if (w_wordDone && w_full && !w_pop) begin
            r_ovfCnt <= sat_inc(r_ovfCnt);
        end
    end

    prng_word_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_wordDone),
        .push_data (w_word),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .rd_data   (out_data)
    );

endmodule

// File: tb/tb_prng_bit_packer.sv
// Directed bench for prng_bit_packer: two instances (no warm-up, warm-up 5)
// driven with hand-built tap sequences and hand-computed expected words.
module tb_prng_bit_packer;

    localparam int N     = 16;
    localparam int W     = 8;
    localparam int TAP   = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         enA, readyA, tapA;
    logic         enB, readyB, tapB;
    logic [N-1:0] noise = '0;
    logic [N-1:0] caA, caB;
    logic [W-1:0] dataA, dataB;
    logic         validA, validB;
    logic [7:0]   ovfA, ovfB;
    logic         busyA, busyB;

    int nChecks = 0;
    int nBad    = 0;

    logic [W-1:0] wordTab [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    logic [W-1:0] bitVecs [4] = '{8'h81, 8'h03, 8'h5A, 8'hC4};

    // Non-tap cells carry noise so a wrong tap index corrupts the words.
    always @(negedge clk) noise <= N'($urandom);
    assign caA = (noise & ~(N'(1) << TAP)) | (N'(tapA) << TAP);
    assign caB = (noise & ~(N'(1) << TAP)) | (N'(tapB) << TAP);

    prng_bit_packer #(.N(N), .W(W), .TAP(TAP), .WARMUP(0), .DEPTH(DEPTH)) dutA (
        .clk(clk), .reset(reset), .en(enA), .ca_state(caA), .out_data(dataA),
        .out_valid(validA), .out_ready(readyA), .ovf_cnt(ovfA), .busy(busyA)
    );

    prng_bit_packer #(.N(N), .W(W), .TAP(TAP), .WARMUP(5), .DEPTH(DEPTH)) dutB (
        .clk(clk), .reset(reset), .en(enB), .ca_state(caB), .out_data(dataB),
        .out_valid(validB), .out_ready(readyB), .ovf_cnt(ovfB), .busy(busyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Feeds one word LSB-first into dutA; readyA takes readyOnLast for the push edge.
    task automatic applyStimulus(input logic [W-1:0] word, input logic readyOnLast);
        for (int k = 0; k < W; k++) begin
            tapA = word[k];
            if (k == W - 1) readyA = readyOnLast;
            stepCycles(1);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        enA = 1'b0; readyA = 1'b0; tapA = 1'b0;
        enB = 1'b0; readyB = 1'b0; tapB = 1'b0;
        stepCycles(2);
        checkOutput("reset_valid", 32'(validA), 32'h0);
        checkOutput("reset_data", 32'(dataA), 32'h0);
        checkOutput("reset_ovf", 32'(ovfA), 32'h0);
        checkOutput("reset_busy", 32'(busyA), 32'h0);
        checkOutput("reset_busyB", 32'(busyB), 32'h0);
        reset = 1'b0;
        stepCycles(1);

        // Warm-up: five ones during warm-up must not leak into the word.
        enB = 1'b1; tapB = 1'b1;
        stepCycles(1);
        checkOutput("warm_busy", 32'(busyB), 32'h1);
        stepCycles(5);
        for (int k = 0; k < W; k++) begin
            tapB = (8'h60 >> k) & 8'h1;
            stepCycles(1);
            if (k == W - 2) checkOutput("warm_valid_E12", 32'(validB), 32'h0);
        end
        checkOutput("warm_valid_E13", 32'(validB), 32'h1);
        checkOutput("warm_data", 32'(dataB), 32'h60);
        enB = 1'b0;

        // All-ones word, first-word latency and steady-state rate.
        tapA = 1'b1; readyA = 1'b1; enA = 1'b1;
        stepCycles(1);
        checkOutput("lat_busy_E0", 32'(busyA), 32'h1);
        stepCycles(7);
        checkOutput("lat_valid_E7", 32'(validA), 32'h0);
        stepCycles(1);
        checkOutput("lat_valid_E8", 32'(validA), 32'h1);
        checkOutput("lat_data_E8", 32'(dataA), 32'hFF);
        stepCycles(1);
        checkOutput("lat_pop_E9", 32'(validA), 32'h0);
        stepCycles(7);
        checkOutput("rate_valid_E16", 32'(validA), 32'h1);
        checkOutput("rate_data_E16", 32'(dataA), 32'hFF);
        enA = 1'b0;
        stepCycles(1);
        checkOutput("idle_valid", 32'(validA), 32'h0);
        checkOutput("idle_busy", 32'(busyA), 32'h0);

        // Bit order: sample k lands in bit k.
        for (int v = 0; v < 4; v++) begin
            readyA = 1'b1; enA = 1'b1;
            stepCycles(1);
            applyStimulus(bitVecs[v], 1'b1);
            checkOutput($sformatf("order_valid_%0d", v), 32'(validA), 32'h1);
            checkOutput($sformatf("order_data_%0d", v), 32'(dataA), 32'(bitVecs[v]));
            enA = 1'b0;
            stepCycles(1);
        end

        // Overflow: seven words with no consumer, four kept, three dropped.
        readyA = 1'b0; enA = 1'b1;
        stepCycles(1);
        for (int j = 0; j < 7; j++) applyStimulus(wordTab[j], 1'b0);
        checkOutput("ovf_count", 32'(ovfA), 32'd3);
        enA = 1'b0;
        stepCycles(1);
        checkOutput("ovf_busy_idle", 32'(busyA), 32'h0);
        checkOutput("ovf_valid_kept", 32'(validA), 32'h1);
        readyA = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("ovf_drain_%0d", j), 32'(dataA), 32'(wordTab[j]));
            stepCycles(1);
        end
        checkOutput("ovf_drained", 32'(validA), 32'h0);

        // Push and pop on the same edge while full.
        readyA = 1'b0; enA = 1'b1;
        stepCycles(1);
        for (int j = 0; j < 4; j++) applyStimulus(wordTab[j], 1'b0);
        applyStimulus(wordTab[4], 1'b1);
        readyA = 1'b0;
        checkOutput("fullpop_ovf", 32'(ovfA), 32'd3);
        enA = 1'b0;
        stepCycles(1);
        readyA = 1'b1;
        for (int j = 1; j < 5; j++) begin
            checkOutput($sformatf("fullpop_drain_%0d", j), 32'(dataA), 32'(wordTab[j]));
            stepCycles(1);
        end
        checkOutput("fullpop_occupancy", 32'(validA), 32'h0);

        // Enable drop discards a partial word of ones.
        readyA = 1'b0; enA = 1'b1; tapA = 1'b1;
        stepCycles(1);
        stepCycles(5);
        enA = 1'b0;
        stepCycles(1);
        checkOutput("drop_busy", 32'(busyA), 32'h0);
        enA = 1'b1;
        stepCycles(1);
        applyStimulus(8'h24, 1'b0);
        checkOutput("drop_valid", 32'(validA), 32'h1);
        checkOutput("drop_data", 32'(dataA), 32'h24);

        // Asynchronous reset mid-COLLECT with a non-empty FIFO.
        tapA = 1'b1;
        stepCycles(3);
        checkOutput("prereset_ovf", 32'(ovfA), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(validA), 32'h0);
        checkOutput("async_ovf", 32'(ovfA), 32'h0);
        checkOutput("async_busy", 32'(busyA), 32'h0);
        checkOutput("async_data", 32'(dataA), 32'h0);
        enA = 1'b0;
        stepCycles(1);
        reset = 1'b0;
        stepCycles(1);

        // Saturation: 4 stored, then 254, 255 and 258 drops.
        readyA = 1'b0; enA = 1'b1;
        stepCycles(1);
        for (int j = 0; j < 258; j++) applyStimulus(8'(j), 1'b0);
        checkOutput("sat_254", 32'(ovfA), 32'd254);
        applyStimulus(8'h55, 1'b0);
        checkOutput("sat_255", 32'(ovfA), 32'd255);
        for (int j = 0; j < 3; j++) applyStimulus(8'hAA, 1'b0);
        checkOutput("sat_hold", 32'(ovfA), 32'd255);
        checkOutput("sat_head", 32'(dataA), 32'h00);
        enA = 1'b0;
        stepCycles(1);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
